// File: rtl/inst_queue_pkg.sv
// Shared defines for the out-of-order core: structure sizes and boolean constants.
package inst_queue_pkg;

    // Reservation station and reorder buffer sizing
    localparam int RSSZ    = 16;
    localparam int ROBIDBW = 4;

    // Instruction queue sizing (IQIDBW = log2(IQSZ))
    localparam int IQSZ    = 16;
    localparam int IQIDBW  = 4;

    // Boolean constants shared across the core
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer between fetch and dispatch.
// Show-ahead head with valid/ready, one push and one pop per cycle,
// single-cycle flush on misprediction. Occupancy count is the only
// full/empty discriminator; pointers wrap by natural overflow.
module inst_queue #(
    parameter int IQSZ   = 16,
    parameter int IQIDBW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [31:0]       if_inst,
    input  logic [31:0]       if_pc,
    output logic              iq_full,
    output logic              id_valid,
    output logic [31:0]       id_inst,
    output logic [31:0]       id_pc,
    input  logic              id_ready,
    input  logic              flush,
    output logic [IQIDBW:0]   iq_count
);
    import inst_queue_pkg::*;

    logic [IQIDBW-1:0] head;
    logic [IQIDBW-1:0] tail;
    logic [IQIDBW:0]   count;
    logic [31:0]       inst_mem [IQSZ];
    logic [31:0]       pc_mem   [IQSZ];

    logic push;
    logic pop;

    // Full is judged on the registered count, so a push while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign push = rdy & if_valid & ~iq_full & ~flush;
    assign pop  = rdy & id_valid & id_ready & ~flush;

    // Pointer/count bookkeeping and entry storage; storage is never reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    inst_mem[tail] <= if_inst;
                    pc_mem[tail]   <= if_pc;
                    tail           <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Status flags and masked head read-out toward dispatch
    always_comb begin
        iq_full  = (count == (IQIDBW+1)'(IQSZ));
        iq_count = count;
        id_valid = False;
        id_inst  = '0;
        id_pc    = '0;
        if (count != '0) begin
            id_valid = True;
            id_inst  = inst_mem[head];
            id_pc    = pc_mem[head];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios plus randomized traffic
// checked against an occupancy model and an expected-entry queue.
module tb_inst_queue;

    localparam int IQSZ   = 16;
    localparam int IQIDBW = 4;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic              iq_full;
    logic              id_valid;
    logic [31:0]       id_inst;
    logic [31:0]       id_pc;
    logic              id_ready;
    logic              flush;
    logic [IQIDBW:0]   iq_count;

    inst_queue #(.IQSZ(IQSZ), .IQIDBW(IQIDBW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .iq_full  (iq_full),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_ready (id_ready),
        .flush    (flush),
        .iq_count (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: occupancy count and FIFO of expected {inst, pc}
    int          mdl_cnt;
    logic [63:0] sb [$];
    int          n_checks;
    int          n_pass;
    bit          mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; model updated just after the edge it applies to
    task automatic cyc(input logic r, input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic rd, input logic fl, output bit acc);
        bit do_push;
        bit do_pop;
        rdy = r; if_valid = v; if_inst = i; if_pc = p; id_ready = rd; flush = fl;
        acc = 0;
        @(posedge clk);
        #1;
        if (r) begin
            if (fl) begin
                mdl_cnt = 0;
                sb.delete();
            end else begin
                do_push = v && (mdl_cnt < IQSZ);
                do_pop  = rd && (mdl_cnt > 0);
                if (do_push) sb.push_back({i, p});
                mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
                acc = do_push;
            end
        end
    endtask

    // Monitor: compares status every cycle, pops the scoreboard on consumption
    always @(negedge clk) begin
        logic [63:0] e;
        if (mon_en && rst) begin
            chk("iq_count", 32'(iq_count), 32'(mdl_cnt));
            chk("iq_full",  32'(iq_full),  32'(mdl_cnt == IQSZ));
            chk("id_valid", 32'(id_valid), 32'(mdl_cnt != 0));
            if (sb.size() == 0) begin
                chk("empty_inst", id_inst, 32'h0);
                chk("empty_pc",   id_pc,   32'h0);
            end else begin
                e = sb[0];
                chk("head_inst", id_inst, e[63:32]);
                chk("head_pc",   id_pc,   e[31:0]);
                if (rdy && id_ready && !flush && id_valid) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [31:0] pc_nxt;
        mdl_cnt = 0; n_checks = 0; n_pass = 0; mon_en = 0;
        rdy = 1; if_valid = 0; if_inst = 0; if_pc = 0; id_ready = 0; flush = 0;

        // Reset and idle
        rst = 0;
        #1;
        chk("rst_async_valid", 32'(id_valid), 32'h0);
        chk("rst_async_count", 32'(iq_count), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        chk("idle_valid", 32'(id_valid), 32'h0);
        chk("idle_count", 32'(iq_count), 32'h0);
        chk("idle_full",  32'(iq_full),  32'h0);
        chk("idle_inst",  id_inst,       32'h0);
        mon_en = 1;

        // In-order fill to full, 17th push dropped, then drain
        for (int k = 0; k < 16; k++) cyc(1, 1, 32'hA000_0000 + 32'(k), 32'(k * 4), 0, 0, acc);
        chk("fill_full",  32'(iq_full),  32'h1);
        chk("fill_count", 32'(iq_count), 32'd16);
        cyc(1, 1, 32'hDEAD_0040, 32'h40, 0, 0, acc);
        chk("drop17_acc",   32'(acc),      32'h0);
        chk("drop17_count", 32'(iq_count), 32'd16);
        for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0, 1, 0, acc);
        chk("drain_valid", 32'(id_valid), 32'h0);

        // Simultaneous push/pop at count=1 and count=16
        cyc(1, 1, 32'hB000_0000, 32'h200, 0, 0, acc);
        cyc(1, 1, 32'hB000_0001, 32'h204, 1, 0, acc);
        chk("pp1_count", 32'(iq_count), 32'd1);
        for (int k = 0; k < 15; k++) cyc(1, 1, 32'hB100_0000 + 32'(k), 32'h300 + 32'(k * 4), 0, 0, acc);
        chk("pp16_full", 32'(iq_full), 32'h1);
        cyc(1, 1, 32'hBEEF_BEEF, 32'h3FC, 1, 0, acc);
        chk("pp16_count", 32'(iq_count), 32'd15);
        chk("pp16_full_fall", 32'(iq_full), 32'h0);
        for (int k = 0; k < 15; k++) cyc(1, 0, 0, 0, 1, 0, acc);

        // Wrap-around at steady count=3
        pc_nxt = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, $urandom, pc_nxt, 0, 0, acc);
            pc_nxt += 4;
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, $urandom, pc_nxt, 1, 0, acc);
            pc_nxt += 4;
        end
        chk("wrap_count", 32'(iq_count), 32'd3);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 0, acc);

        // Flush with 5 entries while pushing and popping
        for (int k = 0; k < 5; k++) cyc(1, 1, $urandom, 32'h2000 + 32'(k * 4), 0, 0, acc);
        cyc(1, 1, 32'hFFFF_0000, 32'h2FF0, 1, 1, acc);
        chk("flush_count", 32'(iq_count), 32'h0);
        chk("flush_valid", 32'(id_valid), 32'h0);
        cyc(1, 1, 32'h1234_5678, 32'h100, 0, 0, acc);
        chk("post_flush_pc", id_pc, 32'h100);

        // rdy freeze while driving push, pop and flush
        cyc(1, 1, 32'h5555_0000, 32'h104, 0, 0, acc);
        for (int k = 0; k < 4; k++) cyc(0, 1, 32'h6666_0000, 32'h108, 1, 1, acc);
        chk("freeze_count", 32'(iq_count), 32'd2);
        chk("freeze_pc",    id_pc,         32'h100);
        cyc(1, 0, 0, 0, 1, 0, acc);
        chk("resume_pc", id_pc, 32'h104);
        cyc(1, 0, 0, 0, 1, 0, acc);

        // Randomized traffic with a fetcher that holds until accepted
        pc_nxt = 32'h8000;
        for (int k = 0; k < 600; k++) begin
            logic r, v, rd, fl;
            r  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 39) == 0);
            cyc(r, v, ~pc_nxt, pc_nxt, rd, fl, acc);
            if (acc) pc_nxt += 4;
            if (k == 300) begin
                // Asynchronous reset mid-operation
                #1;
                rdy = 1; if_valid = 0; id_ready = 0; flush = 0;
                rst = 0;
                #1;
                chk("midrst_valid", 32'(id_valid), 32'h0);
                chk("midrst_count", 32'(iq_count), 32'h0);
                chk("midrst_full",  32'(iq_full),  32'h0);
                chk("midrst_pc",    id_pc,         32'h0);
                mdl_cnt = 0;
                sb.delete();
                @(posedge clk);
                #1;
                rst = 1;
            end
        end
        for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0, 1, 0, acc);
        chk("final_count", 32'(iq_count), 32'h0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular instruction buffer between the fetcher and the dispatch/decode stage that drives the reservation station's `inst_ID_flag` path. It accepts one fetched 32-bit instruction plus PC per cycle and presents the oldest entry to dispatch through a show-ahead valid/ready handshake. On a misprediction flush from the ROB it empties itself in one cycle, so no wrong-path instruction reaches the reservation station.

## Interface
Parameters:
- `IQSZ`, default 16: entry count; power of two, at least 2.
- `IQIDBW`, default 4: log2(`IQSZ`); pointer width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  chip-ready. When low, all state is frozen and push, pop and flush are ignored.
- `if_valid`  in  1  fetcher presents an instruction this cycle.
- `if_inst`  in  32  fetched instruction word.
- `if_pc`  in  32  PC of `if_inst`.
- `iq_full`  out  1  queue holds `IQSZ` entries.
- `id_valid`  out  1  head entry is valid.
- `id_inst`  out  32  head instruction; 0 when `id_valid` is low.
- `id_pc`  out  32  head PC; 0 when `id_valid` is low.
- `id_ready`  in  1  dispatch consumes the head this cycle.
- `flush`  in  1  misprediction or rollback from the ROB; discard all entries.
- `iq_count`  out  `IQIDBW`+1  current occupancy, 0..`IQSZ`.

## Operation
- State: `head` and `tail` pointers (`IQIDBW` bits each), `count` (`IQIDBW`+1 bits), and entry arrays `inst[IQSZ]` and `pc[IQSZ]`.
- Push: `push = rdy & if_valid & !iq_full & !flush`. On a push, the entry at `tail` is written and `tail` increments.
- Pop: `pop = rdy & id_valid & id_ready & !flush`. On a pop, `head` increments.
- `count` update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointers wrap modulo `IQSZ` by natural overflow. `count` is the only full/empty discriminator.
- `iq_full` is computed from registered `count` only. A push while full is dropped, even if a pop happens in the same cycle. The fetcher holds `if_valid` and its data until the push is accepted.
- `id_valid = (count != 0)`. `id_inst` and `id_pc` are read combinationally from the `head` entry and masked to 0 when the queue is empty.
- Flush (`rdy & flush`): `head`, `tail` and `count` become 0 at the next edge. A push or pop in the same cycle is discarded.
- Priority: `rst` > `!rdy` > `flush` > push/pop.
- No bypass. An instruction pushed into an empty queue is not visible on `id_*` in the same cycle.

## Timing
- Reset (asynchronous, `rst` low): `head`, `tail` and `count` are cleared. Consequently `iq_full`=0, `id_valid`=0, `id_inst`=0, `id_pc`=0 and `iq_count`=0 immediately, without waiting for a clock edge.
- Entry arrays are not reset; their contents are don't-care until written.
- Push-to-head latency: 1 cycle. Push at edge N makes `id_valid` high after edge N.
- Throughput: 1 push and 1 pop per cycle sustained, including at `count`=1 and at `count`=`IQSZ`-1.
- Full boundary: `iq_full` rises the cycle after the `IQSZ`-th push. It falls the cycle after any pop.
- Empty boundary: the last pop drops `id_valid` after the same edge.
- Flush: `id_valid`=0 in the cycle after `flush` is sampled. Fetch may push again in that cycle.
- Reset mid-operation discards all contents. Behaviour after `rst` rises is identical to power-up.

## Structure
- Add `IQSZ` and `IQIDBW` to the shared defines header, next to `RSSZ` and `ROBIDBW`.
- Reuse the shared `True`/`False` constants.
- Single flat module; no sub-module. Pointer/count logic and storage live in one sequential process, and output muxing is in one combinational process.

## Test plan
- Reset and idle: hold `rst`=0 for 3 cycles, then release → `id_valid`=0, `iq_count`=0, `iq_full`=0, `id_inst`=0.
- In-order fill and drain: push PCs 0x0, 0x4, … 0x3C with `id_ready`=0 → `iq_full`=1 and `iq_count`=16. The 17th push (PC 0x40) is dropped. Then drain with `id_ready`=1 → PCs come out 0x0 … 0x3C in order, and `id_valid` falls after the 16th pop.
- Simultaneous push and pop with `count`=1 and with `count`=16: `count` stays 1. At `count`=16 the push is dropped, `count` goes to 15 and `iq_full` falls next cycle.
- Wrap-around: run 40 push/pop cycles at steady `count`=3 → the head PC sequence stays consecutive across pointer wrap, with no duplicates or gaps.
- Flush: with 5 entries, assert `flush` together with `if_valid` and `id_ready` → next cycle `iq_count`=0 and `id_valid`=0. A push of PC 0x100 in the following cycle appears at the head one cycle later.
- `rdy` freeze: with `rdy`=0 for 4 cycles while driving push, pop and flush → `iq_count` and the head PC are unchanged. Normal operation resumes when `rdy`=1.
